// File: rtl/suprloco_pkg.sv
// Shared definitions for the Suprloco main-bus responder: region bounds, open-bus value
// and the ROM fetch state encoding used by the top level and the fetch engine.
package suprloco_pkg;

    localparam logic [15:0] ROM_TOP_DEF = 16'hBFFF;
    localparam logic [3:0]  RAM_PAGE    = 4'hE;
    localparam logic [7:0]  OPEN_BUS    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/suprloco_rom_fetch.sv
// ROM fetch engine: one external request per CPU ROM read, latched result held until the CPU
// ends its cycle. Latency = ack time + 1 clock; aborts with open-bus data after TIMEOUT_CYC clocks.
module suprloco_rom_fetch
    import suprloco_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        release_i,
    input  logic [15:0] addr_i,
    input  logic        ack_i,
    input  logic [7:0]  ack_data_i,
    output logic        rom_rd_o,
    output logic [15:0] rom_addr_o,
    output logic [7:0]  data_o,
    output logic        timeout_o,
    output logic        stall_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    fetch_state_e   state_q, state_d;
    logic           rom_rd_q, rom_rd_d;
    logic [15:0]    rom_addr_q, rom_addr_d;
    logic [7:0]     data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            data_q     <= OPEN_BUS;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_rd_d   = rom_rd_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_REQ;
                    rom_rd_d   = 1'b1;
                    rom_addr_d = addr_i;
                    cnt_d      = '0;
                end
            end
            ST_REQ: begin
                // An ack in the last counted clock still wins over the abort.
                if (ack_i) begin
                    data_d   = ack_data_i;
                    rom_rd_d = 1'b0;
                    state_d  = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    data_d    = OPEN_BUS;
                    timeout_d = 1'b1;
                    rom_rd_d  = 1'b0;
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (release_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rom_rd_d = 1'b0;
            end
        endcase
    end

    assign rom_rd_o   = rom_rd_q;
    assign rom_addr_o = rom_addr_q;
    assign data_o     = data_q;
    assign timeout_o  = timeout_q;
    assign stall_o    = (state_q != ST_HOLD);

endmodule

// File: rtl/suprloco_mainbus_responder.sv
// CPU main-bus responder: address decode, ROM fetch with wait insertion, work RAM and I/O read mux.
// RAM and I/O answer without wait; ROM reads hold o_WAIT_n low until the fetch engine has data.
module suprloco_mainbus_responder
    import suprloco_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [15:0] ROM_TOP     = ROM_TOP_DEF
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_PCEN,
    input  logic [15:0] i_ADDR,
    input  logic        i_MREQ_n,
    input  logic        i_IORQ_n,
    input  logic        i_RD_n,
    input  logic        i_WR_n,
    input  logic        i_M1_n,
    input  logic        i_RFSH_n,
    input  logic [7:0]  i_CPU_DO,
    output logic [7:0]  o_CPU_DI,
    output logic        o_WAIT_n,
    output logic        o_ROM_RD,
    output logic [15:0] o_ROM_ADDR,
    input  logic        i_ROM_ACK,
    input  logic [7:0]  i_ROM_DATA,
    output logic [11:0] o_RAM_ADDR,
    output logic [7:0]  o_RAM_DI,
    output logic        o_RAM_WE,
    input  logic [7:0]  i_RAM_DO,
    input  logic [7:0]  i_IO_DI,
    output logic        o_TIMEOUT
);

    logic       is_rom;
    logic       is_ram;
    logic       mem_rd;
    logic       mem_wr;
    logic       rom_strb;
    logic       fetch_stall;
    logic [7:0] fetch_data;
    logic       wr_done_q, wr_done_d;

    assign is_rom   = (i_ADDR <= ROM_TOP);
    assign is_ram   = !is_rom && (i_ADDR[15:12] == RAM_PAGE);
    // Refresh cycles are excluded here so they can never reach ROM or RAM.
    assign mem_rd   = !i_MREQ_n && !i_RD_n && i_RFSH_n;
    assign mem_wr   = !i_MREQ_n && !i_WR_n && i_RFSH_n;
    assign rom_strb = mem_rd && is_rom;

    suprloco_rom_fetch #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rom_fetch (
        .clk_i      (i_CLK),
        .rst_i      (i_RST),
        .start_i    (i_PCEN && rom_strb),
        .release_i  (i_PCEN && i_MREQ_n),
        .addr_i     (i_ADDR),
        .ack_i      (i_ROM_ACK),
        .ack_data_i (i_ROM_DATA),
        .rom_rd_o   (o_ROM_RD),
        .rom_addr_o (o_ROM_ADDR),
        .data_o     (fetch_data),
        .timeout_o  (o_TIMEOUT),
        .stall_o    (fetch_stall)
    );

    // Combinational so the CPU's very first wait sample of a ROM cycle is already low.
    assign o_WAIT_n = !(rom_strb && fetch_stall && !i_RST);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= wr_done_d;
        end
    end

    always_comb begin
        wr_done_d = wr_done_q;
        if (i_PCEN && i_MREQ_n) begin
            wr_done_d = 1'b0;
        end else if (i_PCEN && mem_wr) begin
            wr_done_d = 1'b1;
        end
    end

    assign o_RAM_ADDR = i_ADDR[11:0];
    assign o_RAM_DI   = i_CPU_DO;
    assign o_RAM_WE   = i_PCEN && mem_wr && is_ram && !wr_done_q && !i_RST;

    always_comb begin
        o_CPU_DI = OPEN_BUS;
        if (!i_IORQ_n) begin
            o_CPU_DI = i_M1_n ? i_IO_DI : OPEN_BUS;
        end else if (is_rom) begin
            o_CPU_DI = fetch_data;
        end else if (is_ram) begin
            o_CPU_DI = i_RAM_DO;
        end
    end

endmodule

// File: tb/tb_suprloco_mainbus_responder.sv
// Bench for the main-bus responder: scenario tasks with a RAM stub and a byte-level reference model.
module tb_suprloco_mainbus_responder;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_PCEN;
    logic [15:0] i_ADDR;
    logic        i_MREQ_n, i_IORQ_n, i_RD_n, i_WR_n, i_M1_n, i_RFSH_n;
    logic [7:0]  i_CPU_DO;
    logic [7:0]  o_CPU_DI;
    logic        o_WAIT_n;
    logic        o_ROM_RD;
    logic [15:0] o_ROM_ADDR;
    logic        i_ROM_ACK;
    logic [7:0]  i_ROM_DATA;
    logic [11:0] o_RAM_ADDR;
    logic [7:0]  o_RAM_DI;
    logic        o_RAM_WE;
    logic [7:0]  i_RAM_DO;
    logic [7:0]  i_IO_DI;
    logic        o_TIMEOUT;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ram_mem [4096];
    logic [7:0]  ref_ram [logic [11:0]];
    logic [11:0] wkeys [$];

    suprloco_mainbus_responder dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_PCEN(i_PCEN), .i_ADDR(i_ADDR),
        .i_MREQ_n(i_MREQ_n), .i_IORQ_n(i_IORQ_n), .i_RD_n(i_RD_n), .i_WR_n(i_WR_n),
        .i_M1_n(i_M1_n), .i_RFSH_n(i_RFSH_n), .i_CPU_DO(i_CPU_DO), .o_CPU_DI(o_CPU_DI),
        .o_WAIT_n(o_WAIT_n), .o_ROM_RD(o_ROM_RD), .o_ROM_ADDR(o_ROM_ADDR),
        .i_ROM_ACK(i_ROM_ACK), .i_ROM_DATA(i_ROM_DATA), .o_RAM_ADDR(o_RAM_ADDR),
        .o_RAM_DI(o_RAM_DI), .o_RAM_WE(o_RAM_WE), .i_RAM_DO(i_RAM_DO),
        .i_IO_DI(i_IO_DI), .o_TIMEOUT(o_TIMEOUT)
    );

    always #5 i_CLK = ~i_CLK;

    // Work RAM stub with one clock of read latency.
    always @(posedge i_CLK) begin
        if (o_RAM_WE) ram_mem[o_RAM_ADDR] <= o_RAM_DI;
        i_RAM_DO <= ram_mem[o_RAM_ADDR];
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic next();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic bus_idle();
        i_MREQ_n = 1'b1; i_IORQ_n = 1'b1; i_RD_n = 1'b1; i_WR_n = 1'b1;
        i_M1_n = 1'b1; i_RFSH_n = 1'b1; i_ROM_ACK = 1'b0; i_PCEN = 1'b1;
    endtask

    task automatic do_fetch(input logic [15:0] a, input int dly, input logic [7:0] d, input bit m1,
                            output logic [7:0] got, output int rd_cyc, output int wait_lo,
                            output logic [15:0] got_addr, output logic hold_wait, output bit hung);
        i_ADDR = a; i_MREQ_n = 1'b0; i_RD_n = 1'b0; i_WR_n = 1'b1; i_IORQ_n = 1'b1;
        i_M1_n = !m1; i_RFSH_n = 1'b1;
        rd_cyc = 0; wait_lo = 0; got_addr = '0; hung = 1'b1;
        @(negedge i_CLK);
        wait_lo += int'(!o_WAIT_n);
        next();
        for (int n = 0; n < 400; n++) begin
            i_ROM_ACK  = (n == dly);
            i_ROM_DATA = (n == dly) ? d : 8'($urandom);
            @(negedge i_CLK);
            if (!o_ROM_RD) begin
                hung = 1'b0;
                break;
            end
            rd_cyc++;
            got_addr = o_ROM_ADDR;
            wait_lo += int'(!o_WAIT_n);
            next();
        end
        i_ROM_ACK = 1'b0;
        hold_wait = o_WAIT_n;
        got = o_CPU_DI;
        next();
        i_MREQ_n = 1'b1; i_RD_n = 1'b1; i_M1_n = 1'b1;
        @(negedge i_CLK);
        next();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int we_cnt,
                            output logic [11:0] we_a, output logic [7:0] we_d,
                            output int rd_hi, output int wait_lo);
        i_ADDR = a; i_CPU_DO = d; i_MREQ_n = 1'b0; i_RD_n = 1'b1; i_WR_n = 1'b1;
        i_RFSH_n = 1'b1; i_M1_n = 1'b1; i_IORQ_n = 1'b1;
        we_cnt = 0; we_a = '0; we_d = '0; rd_hi = 0; wait_lo = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) i_WR_n = 1'b0;
            if (k == 4) begin i_WR_n = 1'b1; i_MREQ_n = 1'b1; end
            @(negedge i_CLK);
            if (o_RAM_WE) begin we_cnt++; we_a = o_RAM_ADDR; we_d = o_RAM_DI; end
            rd_hi += int'(o_ROM_RD);
            wait_lo += int'(!o_WAIT_n);
            next();
        end
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] got, output int wait_lo,
                           output int rd_hi);
        i_ADDR = a; i_MREQ_n = 1'b0; i_RD_n = 1'b0; i_RFSH_n = 1'b1; i_M1_n = 1'b1;
        i_IORQ_n = 1'b1; i_WR_n = 1'b1;
        wait_lo = 0; rd_hi = 0; got = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_CLK);
            wait_lo += int'(!o_WAIT_n);
            rd_hi += int'(o_ROM_RD);
            got = o_CPU_DI;
            next();
        end
        i_MREQ_n = 1'b1; i_RD_n = 1'b1;
        @(negedge i_CLK);
        next();
    endtask

    task automatic do_io(input bit intack, input logic [7:0] io, output logic [7:0] got,
                         output int wait_lo, output int rd_hi);
        i_ADDR = 16'($urandom); i_IO_DI = io; i_MREQ_n = 1'b1; i_IORQ_n = 1'b0;
        i_M1_n = !intack; i_RD_n = intack; i_RFSH_n = 1'b1;
        @(negedge i_CLK);
        got = o_CPU_DI; wait_lo = int'(!o_WAIT_n); rd_hi = int'(o_ROM_RD);
        next();
        i_IORQ_n = 1'b1; i_M1_n = 1'b1; i_RD_n = 1'b1;
        @(negedge i_CLK);
        next();
    endtask

    task automatic test_reset();
        i_RST = 1'b1; i_ADDR = 16'h0123; i_MREQ_n = 1'b0; i_RD_n = 1'b0; i_ROM_ACK = 1'b1;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        n_vec++; if (o_ROM_RD !== 1'b0) begin n_err++; $display("FAIL reset_rom_rd: got %b want 0", o_ROM_RD); end
        n_vec++; if (o_WAIT_n !== 1'b1) begin n_err++; $display("FAIL reset_wait_n: got %b want 1", o_WAIT_n); end
        n_vec++; if (o_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_TIMEOUT); end
        n_vec++; if (o_ROM_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_rom_addr: got %h want 0000", o_ROM_ADDR); end
        n_vec++; if (o_CPU_DI !== 8'hFF) begin n_err++; $display("FAIL reset_latched: got %h want ff", o_CPU_DI); end
        i_ADDR = 16'hE010; i_RD_n = 1'b1; i_WR_n = 1'b0;
        @(negedge i_CLK);
        n_vec++; if (o_RAM_WE !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", o_RAM_WE); end
        bus_idle();
        @(negedge i_CLK);
        i_RST = 1'b0;
        next();
    endtask

    task automatic test_fetch_basic();
        logic [7:0] got; int rd_cyc, wait_lo; logic [15:0] ga; logic hw; bit hung;
        do_fetch(16'h0123, 5, 8'h3E, 1'b1, got, rd_cyc, wait_lo, ga, hw, hung);
        n_vec++; if (hung) begin n_err++; $display("FAIL fetch_end: got hung want done"); end
        n_vec++; if (got !== 8'h3E) begin n_err++; $display("FAIL fetch_data: got %h want 3e", got); end
        n_vec++; if (rd_cyc != 6) begin n_err++; $display("FAIL fetch_rd_cycles: got %0d want 6", rd_cyc); end
        n_vec++; if (wait_lo != 7) begin n_err++; $display("FAIL fetch_wait_cycles: got %0d want 7", wait_lo); end
        n_vec++; if (ga !== 16'h0123) begin n_err++; $display("FAIL fetch_rom_addr: got %h want 0123", ga); end
        n_vec++; if (hw !== 1'b1) begin n_err++; $display("FAIL fetch_hold_wait: got %b want 1", hw); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, d; int rd_cyc, wait_lo, dly; logic [15:0] ga, a; logic hw; bit hung;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(0, 16'hBFFF)); d = 8'($urandom); dly = $urandom_range(0, 4);
            do_fetch(a, dly, d, i[0], got, rd_cyc, wait_lo, ga, hw, hung);
            n_vec++; if (got !== d) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got, d); end
            n_vec++; if (rd_cyc != dly + 1) begin n_err++; $display("FAIL b2b_rd_cycles[%0d]: got %0d want %0d", i, rd_cyc, dly + 1); end
            n_vec++; if (ga !== a) begin n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, ga, a); end
        end
    endtask

    task automatic test_ram();
        int we_cnt, rd_hi, wait_lo; logic [11:0] wa; logic [7:0] wd, got;
        do_write(16'hE010, 8'hA5, we_cnt, wa, wd, rd_hi, wait_lo);
        ref_ram[12'h010] = 8'hA5; wkeys.push_back(12'h010);
        n_vec++; if (we_cnt != 1) begin n_err++; $display("FAIL ram_we_pulses: got %0d want 1", we_cnt); end
        n_vec++; if (wa !== 12'h010) begin n_err++; $display("FAIL ram_we_addr: got %h want 010", wa); end
        n_vec++; if (wd !== 8'hA5) begin n_err++; $display("FAIL ram_we_data: got %h want a5", wd); end
        do_read(16'hE010, got, wait_lo, rd_hi);
        n_vec++; if (got !== 8'hA5) begin n_err++; $display("FAIL ram_readback: got %h want a5", got); end
        n_vec++; if (wait_lo != 0 || rd_hi != 0) begin n_err++; $display("FAIL ram_no_wait: got wait %0d rd %0d want 0 0", wait_lo, rd_hi); end
    endtask

    task automatic test_refresh();
        int rd_hi, wait_lo, we, we_cnt; logic [11:0] wa; logic [7:0] wd;
        i_ADDR = 16'h0040; i_MREQ_n = 1'b0; i_RFSH_n = 1'b0; i_RD_n = 1'b0; i_M1_n = 1'b1;
        rd_hi = 0; wait_lo = 0; we = 0;
        repeat (3) begin
            @(negedge i_CLK);
            rd_hi += int'(o_ROM_RD); wait_lo += int'(!o_WAIT_n); we += int'(o_RAM_WE);
            next();
        end
        bus_idle();
        @(negedge i_CLK);
        next();
        n_vec++; if (rd_hi != 0 || wait_lo != 0 || we != 0) begin n_err++; $display("FAIL refresh_quiet: got rd %0d wait %0d we %0d want 0 0 0", rd_hi, wait_lo, we); end
        do_write(16'h1000, 8'h5A, we_cnt, wa, wd, rd_hi, wait_lo);
        n_vec++; if (we_cnt != 0 || rd_hi != 0 || wait_lo != 0) begin n_err++; $display("FAIL rom_write_quiet: got we %0d rd %0d wait %0d want 0 0 0", we_cnt, rd_hi, wait_lo); end
    endtask

    task automatic test_io();
        logic [7:0] got, io; int wait_lo, rd_hi;
        io = 8'($urandom);
        do_io(1'b0, io, got, wait_lo, rd_hi);
        n_vec++; if (got !== io) begin n_err++; $display("FAIL io_read: got %h want %h", got, io); end
        n_vec++; if (wait_lo != 0) begin n_err++; $display("FAIL io_wait: got %0d want 0", wait_lo); end
        do_io(1'b1, 8'h3C, got, wait_lo, rd_hi);
        n_vec++; if (got !== 8'hFF) begin n_err++; $display("FAIL int_ack: got %h want ff", got); end
    endtask

    task automatic test_open_bus();
        logic [7:0] got; int wait_lo, rd_hi;
        do_read(16'hC000 + 16'($urandom_range(0, 16'h1FFF)), got, wait_lo, rd_hi);
        n_vec++; if (got !== 8'hFF || wait_lo != 0 || rd_hi != 0) begin n_err++; $display("FAIL open_bus_c: got %h wait %0d rd %0d want ff 0 0", got, wait_lo, rd_hi); end
        do_read(16'hF000 + 16'($urandom_range(0, 16'h0FFF)), got, wait_lo, rd_hi);
        n_vec++; if (got !== 8'hFF || wait_lo != 0 || rd_hi != 0) begin n_err++; $display("FAIL open_bus_f: got %h wait %0d rd %0d want ff 0 0", got, wait_lo, rd_hi); end
    endtask

    task automatic test_stray_ack();
        logic [7:0] got; int rd_cyc, wait_lo; logic [15:0] ga; logic hw; bit hung;
        do_fetch(16'h0200, 1, 8'h6D, 1'b0, got, rd_cyc, wait_lo, ga, hw, hung);
        i_ADDR = 16'h0200; i_ROM_ACK = 1'b1; i_ROM_DATA = 8'h92;
        next();
        i_ROM_ACK = 1'b0;
        @(negedge i_CLK);
        n_vec++; if (o_CPU_DI !== 8'h6D) begin n_err++; $display("FAIL stray_ack_data: got %h want 6d", o_CPU_DI); end
        n_vec++; if (o_ROM_RD !== 1'b0) begin n_err++; $display("FAIL stray_ack_rd: got %b want 0", o_ROM_RD); end
        next();
    endtask

    task automatic test_pcen();
        int rd_hi, wait_lo, cnt, bad; logic [7:0] got;
        i_PCEN = 1'b0; i_ADDR = 16'h2222; i_MREQ_n = 1'b0; i_RD_n = 1'b0;
        rd_hi = 0; wait_lo = 0;
        repeat (3) begin
            @(negedge i_CLK);
            rd_hi += int'(o_ROM_RD); wait_lo += int'(!o_WAIT_n);
            next();
        end
        n_vec++; if (rd_hi != 0 || wait_lo != 3) begin n_err++; $display("FAIL pcen_gate_start: got rd %0d wait %0d want 0 3", rd_hi, wait_lo); end
        i_PCEN = 1'b1;
        next();
        @(negedge i_CLK);
        n_vec++; if (o_ROM_RD !== 1'b1 || o_ROM_ADDR !== 16'h2222) begin n_err++; $display("FAIL pcen_start: got rd %b addr %h want 1 2222", o_ROM_RD, o_ROM_ADDR); end
        i_ROM_ACK = 1'b1; i_ROM_DATA = 8'h77;
        next();
        i_ROM_ACK = 1'b0;
        @(negedge i_CLK);
        n_vec++; if (o_CPU_DI !== 8'h77 || o_WAIT_n !== 1'b1) begin n_err++; $display("FAIL pcen_fetch: got %h wait %b want 77 1", o_CPU_DI, o_WAIT_n); end
        // Bus cycle ends while PCEN is low, so the engine must still be holding.
        i_PCEN = 1'b0; i_MREQ_n = 1'b1; i_RD_n = 1'b1;
        next(); next();
        i_PCEN = 1'b1; i_ADDR = 16'h3333; i_MREQ_n = 1'b0; i_RD_n = 1'b0;
        next();
        @(negedge i_CLK);
        n_vec++; if (o_ROM_RD !== 1'b0 || o_WAIT_n !== 1'b1) begin n_err++; $display("FAIL hold_no_restart: got rd %b wait %b want 0 1", o_ROM_RD, o_WAIT_n); end
        i_MREQ_n = 1'b1; i_RD_n = 1'b1;
        next();
        i_ADDR = 16'hE123; i_CPU_DO = 8'h5C; i_MREQ_n = 1'b0; i_WR_n = 1'b0;
        cnt = 0; bad = 0;
        for (int k = 0; k < 8; k++) begin
            i_PCEN = (k % 2 == 1);
            @(negedge i_CLK);
            if (o_RAM_WE) begin cnt++; if (!i_PCEN) bad++; end
            next();
        end
        i_PCEN = 1'b1; i_MREQ_n = 1'b1; i_WR_n = 1'b1;
        next();
        ref_ram[12'h123] = 8'h5C; wkeys.push_back(12'h123);
        n_vec++; if (cnt != 1 || bad != 0) begin n_err++; $display("FAIL pcen_we_pulse: got %0d pulses %0d off-pcen want 1 0", cnt, bad); end
        do_read(16'hE123, got, wait_lo, rd_hi);
        n_vec++; if (got !== 8'h5C) begin n_err++; $display("FAIL pcen_readback: got %h want 5c", got); end
    endtask

    task automatic test_reset_mid_req();
        logic [7:0] got; int rd_cyc, wait_lo; logic [15:0] ga; logic hw; bit hung;
        i_ADDR = 16'h0456; i_MREQ_n = 1'b0; i_RD_n = 1'b0; i_PCEN = 1'b1;
        next();
        repeat (3) next();
        @(negedge i_CLK);
        n_vec++; if (o_ROM_RD !== 1'b1) begin n_err++; $display("FAIL midreq_active: got %b want 1", o_ROM_RD); end
        #1 i_RST = 1'b1;
        #1;
        n_vec++; if (o_ROM_RD !== 1'b0 || o_WAIT_n !== 1'b1) begin n_err++; $display("FAIL midreq_abort: got rd %b wait %b want 0 1", o_ROM_RD, o_WAIT_n); end
        i_MREQ_n = 1'b1; i_RD_n = 1'b1;
        next();
        @(negedge i_CLK);
        i_RST = 1'b0;
        next();
        i_ROM_ACK = 1'b1; i_ROM_DATA = 8'hEE;
        next();
        i_ROM_ACK = 1'b0;
        @(negedge i_CLK);
        n_vec++; if (o_ROM_RD !== 1'b0 || o_WAIT_n !== 1'b1) begin n_err++; $display("FAIL late_ack_rd: got rd %b wait %b want 0 1", o_ROM_RD, o_WAIT_n); end
        n_vec++; if (o_CPU_DI !== 8'hFF || o_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL late_ack_data: got %h to %b want ff 0", o_CPU_DI, o_TIMEOUT); end
        next();
        do_fetch(16'h0456, 2, 8'h11, 1'b0, got, rd_cyc, wait_lo, ga, hw, hung);
        n_vec++; if (got !== 8'h11 || rd_cyc != 3) begin n_err++; $display("FAIL post_reset_fetch: got %h rd %0d want 11 3", got, rd_cyc); end
    endtask

    task automatic test_random();
        logic [7:0] got, d; int rd_cyc, wait_lo, rd_hi, we_cnt, dly, op;
        logic [15:0] ga, a; logic hw; bit hung; logic [11:0] wa, key; logic [7:0] wd;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            d = 8'($urandom);
            case (op)
                0: begin
                    a = 16'($urandom_range(0, 16'hBFFF)); dly = $urandom_range(0, 10);
                    do_fetch(a, dly, d, ($urandom_range(0, 1) == 1), got, rd_cyc, wait_lo, ga, hw, hung);
                    n_vec++; if (got !== d || rd_cyc != dly + 1 || ga !== a || wait_lo != dly + 2) begin n_err++; $display("FAIL rnd_fetch[%0d]: got %h/%0d/%h/%0d want %h/%0d/%h/%0d", i, got, rd_cyc, ga, wait_lo, d, dly + 1, a, dly + 2); end
                end
                1: begin
                    a = {4'hE, 12'($urandom)};
                    do_write(a, d, we_cnt, wa, wd, rd_hi, wait_lo);
                    ref_ram[a[11:0]] = d; wkeys.push_back(a[11:0]);
                    n_vec++; if (we_cnt != 1 || wa !== a[11:0] || wd !== d) begin n_err++; $display("FAIL rnd_write[%0d]: got %0d/%h/%h want 1/%h/%h", i, we_cnt, wa, wd, a[11:0], d); end
                end
                2: begin
                    key = wkeys[$urandom_range(0, wkeys.size() - 1)];
                    do_read({4'hE, key}, got, wait_lo, rd_hi);
                    n_vec++; if (got !== ref_ram[key] || wait_lo != 0) begin n_err++; $display("FAIL rnd_ram_read[%0d]: got %h wait %0d want %h 0", i, got, wait_lo, ref_ram[key]); end
                end
                3: begin
                    dly = $urandom_range(0, 1);
                    do_io(dly == 1, d, got, wait_lo, rd_hi);
                    n_vec++; if (got !== ((dly == 1) ? 8'hFF : d)) begin n_err++; $display("FAIL rnd_io[%0d]: got %h want %h", i, got, (dly == 1) ? 8'hFF : d); end
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? 16'hF000 + 16'($urandom_range(0, 16'h0FFF))
                                                    : 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
                    do_read(a, got, wait_lo, rd_hi);
                    n_vec++; if (got !== 8'hFF || rd_hi != 0) begin n_err++; $display("FAIL rnd_open[%0d]: got %h rd %0d want ff 0", i, got, rd_hi); end
                end
            endcase
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got; int rd_cyc, wait_lo; logic [15:0] ga; logic hw; bit hung;
        do_fetch(16'h0800, -1, 8'h00, 1'b0, got, rd_cyc, wait_lo, ga, hw, hung);
        n_vec++; if (hung) begin n_err++; $display("FAIL timeout_end: got hung want abort"); end
        n_vec++; if (got !== 8'hFF) begin n_err++; $display("FAIL timeout_data: got %h want ff", got); end
        n_vec++; if (rd_cyc != 255 || wait_lo != 256) begin n_err++; $display("FAIL timeout_cycles: got rd %0d wait %0d want 255 256", rd_cyc, wait_lo); end
        n_vec++; if (o_TIMEOUT !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", o_TIMEOUT); end
        do_fetch(16'h0801, 1, 8'h42, 1'b0, got, rd_cyc, wait_lo, ga, hw, hung);
        n_vec++; if (got !== 8'h42 || o_TIMEOUT !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %h to %b want 42 1", got, o_TIMEOUT); end
        @(negedge i_CLK);
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        #1;
        n_vec++; if (o_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", o_TIMEOUT); end
    endtask

    initial begin
        i_ADDR = '0; i_CPU_DO = '0; i_ROM_DATA = '0; i_IO_DI = '0; i_RAM_DO = '0;
        bus_idle();
        test_reset();
        test_fetch_basic();
        test_back_to_back();
        test_ram();
        test_refresh();
        test_io();
        test_open_bus();
        test_stray_ack();
        test_pcen();
        test_reset_mid_req();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
